// File: rtl/vga_fetch_burst_ctrl.sv
// Fetch controller: paces the sequencer, runs one burst per request (cache first, FML on miss), makes pixel enable.
// Latency: burst accepted in IDLE the cycle seq_stb & can_go; BURST_LEN+3 cycles per cache hit, more on FML wait.
// Backpressure: bursts start only while fifo_level <= burst_thresh and the FIFO is not full; fml_stb holds until fml_ack.
module vga_fetch_burst_ctrl #(
  parameter int ADR_W     = 20,
  parameter int BURST_LEN = 8,
  parameter int LVL_W     = 10,
  parameter int DIV_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cache_en,
  input  logic [LVL_W-1:0] burst_thresh,
  input  logic [DIV_W-1:0] pix_div,
  input  logic [15:0]      start_addr,
  input  logic [ADR_W-2:0] seq_adr,
  input  logic             seq_stb,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             seq_en,
  output logic             seq_src_cache,
  output logic [ADR_W-1:0] fml_adr,
  output logic             fml_stb,
  input  logic             fml_ack,
  output logic [ADR_W-1:0] dcb_adr,
  output logic             dcb_stb,
  input  logic             dcb_hit,
  output logic             pix_en,
  output logic             pal_en,
  output logic             underrun,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt,
  input  logic             clr_stats,
  output logic             busy
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int IW = BW + 1;
  localparam int SW = ADR_W + 17;
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_TRY, S_CHK, S_CBEAT, S_FREQ, S_FBEAT
  } state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  b, b_nxt;
  logic [IW-1:0]  idx;
  logic [DIV_W-1:0] cnt;
  logic           can_go, load_adr, inc_hit, inc_miss;
  logic           seq_en_c, src_c, fml_stb_c, dcb_stb_c;
  logic [SW-1:0]  adr_sum;

  assign can_go = (fifo_level <= burst_thresh) & ~fifo_full;

  // Word address plus the display base, converted to a byte address.
  assign adr_sum = SW'(seq_adr) + SW'({start_addr[15:1], 2'b00});

  // Next-state and strobe decode for the burst sequencer.
  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    load_adr  = 1'b0;
    inc_hit   = 1'b0;
    inc_miss  = 1'b0;
    seq_en_c  = 1'b0;
    src_c     = 1'b0;
    fml_stb_c = 1'b0;
    dcb_stb_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_go) begin
          seq_en_c = 1'b1;
          if (seq_stb) begin
            load_adr  = 1'b1;
            state_nxt = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        seq_en_c  = 1'b1;
        state_nxt = cache_en ? S_TRY : S_FREQ;
      end
      S_TRY: begin
        dcb_stb_c = 1'b1;
        seq_en_c  = 1'b1;
        state_nxt = S_CHK;
      end
      S_CHK: begin
        src_c = 1'b1;
        if (dcb_hit) begin
          dcb_stb_c = 1'b1;
          seq_en_c  = 1'b1;
          b_nxt     = BW'(1);
          inc_hit   = 1'b1;
          state_nxt = S_CBEAT;
        end else begin
          inc_miss  = 1'b1;
          state_nxt = S_FREQ;
        end
      end
      S_CBEAT: begin
        src_c     = 1'b1;
        seq_en_c  = 1'b1;
        dcb_stb_c = (b != B_LAST);
        b_nxt     = b + 1'b1;
        if (b == B_LAST) state_nxt = S_IDLE;
      end
      S_FREQ: begin
        fml_stb_c = 1'b1;
        if (fml_ack) begin
          seq_en_c  = 1'b1;
          b_nxt     = BW'(1);
          state_nxt = S_FBEAT;
        end
      end
      S_FBEAT: begin
        seq_en_c = 1'b1;
        b_nxt    = b + 1'b1;
        if (b == B_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are forced low while reset is held so nothing leaks out mid-reset.
  assign seq_en        = seq_en_c  & rst_n;
  assign seq_src_cache = src_c     & rst_n;
  assign fml_stb       = fml_stb_c & rst_n;
  assign dcb_stb       = dcb_stb_c & rst_n;
  assign pal_en        = pix_en & ~fifo_empty & rst_n;
  assign busy          = (state != S_IDLE);
  assign dcb_adr       = fml_adr + ADR_W'({idx, 1'b0});

  // State, beat counter, burst address and cache line index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      b       <= '0;
      fml_adr <= '0;
      idx     <= '0;
    end else begin
      state <= state_nxt;
      b     <= b_nxt;
      if (load_adr) fml_adr <= {adr_sum[ADR_W-2:0], 1'b0};
      idx <= dcb_stb_c ? idx + 1'b1 : '0;
    end
  end

  // Free-running pixel divider; a smaller pix_div than cnt wraps on the next compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (cnt == '0);
      cnt    <= (cnt >= pix_div) ? '0 : cnt + 1'b1;
    end
  end

  // Saturating hit/miss counters and sticky underrun; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      underrun <= 1'b0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      if (inc_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 1'b1;
      if (inc_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 1'b1;
      if (pix_en && fifo_empty)             underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fetch_burst_ctrl.sv
// Bench for vga_fetch_burst_ctrl: random idle traffic and bursts against a transaction-level trace model.
// Latency: inputs change 1 ns after the rising edge, outputs are compared on the falling edge.
// Backpressure: the bench plans fml_ack/dcb_hit per burst and drives them at the planned cycle.
module tb_vga_fetch_burst_ctrl;
  localparam int ADR_W = 20;
  localparam int BL    = 8;
  localparam int LVL_W = 10;
  localparam int DIV_W = 2;

  logic             clk = 1'b0;
  logic             rst_n, cache_en, seq_stb, fifo_full, fifo_empty, fml_ack, dcb_hit, clr_stats;
  logic [LVL_W-1:0] burst_thresh, fifo_level;
  logic [DIV_W-1:0] pix_div;
  logic [15:0]      start_addr;
  logic [ADR_W-2:0] seq_adr;
  logic             seq_en, seq_src_cache, fml_stb, dcb_stb, pix_en, pal_en, underrun, busy;
  logic [ADR_W-1:0] fml_adr, dcb_adr;
  logic [15:0]      hit_cnt, miss_cnt;

  vga_fetch_burst_ctrl #(.ADR_W(ADR_W), .BURST_LEN(BL), .LVL_W(LVL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cache_en(cache_en), .burst_thresh(burst_thresh), .pix_div(pix_div),
    .start_addr(start_addr), .seq_adr(seq_adr), .seq_stb(seq_stb), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .seq_en(seq_en), .seq_src_cache(seq_src_cache),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack), .dcb_adr(dcb_adr), .dcb_stb(dcb_stb),
    .dcb_hit(dcb_hit), .pix_en(pix_en), .pal_en(pal_en), .underrun(underrun), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .clr_stats(clr_stats), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          k;
  logic        exp_pix, exp_und;
  int          exp_hit, exp_miss;
  logic [19:0] exp_fadr, plan_adr;
  logic        ev_hit, ev_miss, ev_load;

  typedef struct {
    bit se; bit src; bit fs; bit ds; logic [19:0] da;
  } step_t;
  step_t tr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic step_t mk(bit se, bit src, bit fs, bit ds, logic [19:0] da);
    step_t s;
    s.se = se; s.src = src; s.fs = fs; s.ds = ds; s.da = da;
    return s;
  endfunction

  // Called on the falling edge: common checks, then advance the model across the next rising edge.
  task automatic tick();
    chk("pix_en", pix_en, exp_pix);
    chk("pal_en", pal_en, exp_pix & ~fifo_empty & rst_n);
    chk("underrun", underrun, exp_und);
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
    chk("fml_adr", fml_adr, exp_fadr);
    if (!rst_n) begin
      k = 0; exp_pix = 1'b0; exp_und = 1'b0; exp_hit = 0; exp_miss = 0; exp_fadr = '0;
    end else begin
      exp_und = clr_stats ? 1'b0 : (exp_und | (exp_pix & fifo_empty));
      if (clr_stats) begin
        exp_hit = 0; exp_miss = 0;
      end else begin
        if (ev_hit && exp_hit < 65535) exp_hit++;
        if (ev_miss && exp_miss < 65535) exp_miss++;
      end
      if (ev_load) exp_fadr = plan_adr;
      k++;
      exp_pix = (((k - 1) % (int'(pix_div) + 1)) == 0);
    end
    ev_hit = 1'b0; ev_miss = 1'b0; ev_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_seq_en"}, seq_en, 1'b0);
    chk({tag, "_fml_stb"}, fml_stb, 1'b0);
    chk({tag, "_dcb_stb"}, dcb_stb, 1'b0);
    chk({tag, "_src"}, seq_src_cache, 1'b0);
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0; seq_stb = $urandom_range(0, 1); fifo_empty = $urandom_range(0, 1);
    fifo_level = '0; fifo_full = 1'b0;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_busy", busy, 1'b0);
    tick();
  endtask

  task automatic idle_cycle(input bit force_empty);
    rst_n = 1'b1; seq_stb = 1'b0; clr_stats = 1'b0;
    burst_thresh = LVL_W'($urandom_range(0, 1023));
    fifo_level   = ($urandom_range(0, 1)) ? LVL_W'(burst_thresh + $urandom_range(0, 3) - 2)
                                          : LVL_W'($urandom_range(0, 1023));
    fifo_full  = ($urandom_range(0, 3) == 0);
    fifo_empty = force_empty ? 1'b1 : 1'(($urandom_range(0, 2) == 0));
    cache_en = $urandom_range(0, 1); dcb_hit = $urandom_range(0, 1); fml_ack = $urandom_range(0, 1);
    @(negedge clk);
    chk("idle_seq_en", seq_en, (fifo_level <= burst_thresh) && !fifo_full);
    chk("idle_fml_stb", fml_stb, 1'b0);
    chk("idle_dcb_stb", dcb_stb, 1'b0);
    chk("idle_src", seq_src_cache, 1'b0);
    chk("idle_busy", busy, 1'b0);
    tick();
  endtask

  // path: 0 = cache disabled, 1 = cache hit, 2 = cache miss. Negative args mean "random"/"none".
  task automatic run_burst(input int path, input int w, input int clr_at, input int rst_at,
                           input int lvl, input int sadr, input int sbase);
    logic [31:0] t;
    logic [18:0] sa;
    logic [15:0] st;
    int chk_idx, freq_start, ack_idx;
    sa = (sadr < 0) ? 19'($urandom) : 19'(sadr);
    st = (sbase < 0) ? 16'($urandom) : 16'(sbase);
    t = {13'b0, sa} + {15'b0, st[15:1], 2'b00};
    plan_adr = {t[18:0], 1'b0};
    chk_idx = -1; freq_start = 1 << 20; ack_idx = -1;
    tr.delete();
    tr.push_back(mk(1, 0, 0, 0, 0));
    tr.push_back(mk(1, 0, 0, 0, 0));
    if (path != 0) begin
      tr.push_back(mk(1, 0, 0, 1, plan_adr));
      chk_idx = tr.size();
      if (path == 1) begin
        tr.push_back(mk(1, 1, 0, 1, plan_adr + 20'd2));
        for (int bb = 1; bb < BL; bb++)
          tr.push_back(mk(1, 1, 0, (bb != BL - 1), plan_adr + 20'(2 * (bb + 1))));
      end else begin
        tr.push_back(mk(0, 1, 0, 0, 0));
      end
    end
    if (path != 1) begin
      freq_start = tr.size();
      ack_idx = freq_start + w;
      for (int ww = 0; ww <= w; ww++) tr.push_back(mk(ww == w, 0, 1, 0, 0));
      for (int bb = 1; bb < BL; bb++) tr.push_back(mk(1, 0, 0, 0, 0));
    end
    for (int i = 0; i < tr.size(); i++) begin
      cache_en = (path != 0);
      dcb_hit  = (path == 1) ? 1'b1 : (path == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      fml_ack  = (i == ack_idx) | ((i < freq_start || i > ack_idx) & 1'($urandom_range(0, 1)));
      clr_stats = (i == clr_at);
      rst_n = (i != rst_at);
      fifo_empty = ($urandom_range(0, 2) == 0);
      if (i == 0) begin
        seq_adr = sa; start_addr = st;
        burst_thresh = (lvl < 0) ? LVL_W'($urandom_range(0, 1023)) : LVL_W'(lvl);
        fifo_level = (lvl < 0) ? LVL_W'($urandom_range(0, int'(burst_thresh))) : LVL_W'(lvl);
        fifo_full = 1'b0; seq_stb = 1'b1; ev_load = 1'b1;
      end else begin
        seq_stb = $urandom_range(0, 1); seq_adr = 19'($urandom); start_addr = 16'($urandom);
        fifo_level = LVL_W'($urandom_range(0, 1023)); fifo_full = $urandom_range(0, 1);
      end
      ev_hit  = (i == chk_idx) && (path == 1);
      ev_miss = (i == chk_idx) && (path == 2);
      @(negedge clk);
      if (rst_n) begin
        chk("seq_en", seq_en, tr[i].se);
        chk("seq_src_cache", seq_src_cache, tr[i].src);
        chk("fml_stb", fml_stb, tr[i].fs);
        chk("dcb_stb", dcb_stb, tr[i].ds);
        if (tr[i].ds) chk("dcb_adr", dcb_adr, tr[i].da);
        chk("busy", busy, (i != 0));
      end else begin
        chk_quiet("midrst");
        chk("midrst_busy", busy, 1'b1);
      end
      tick();
      if (i == rst_at) break;
    end
    clr_stats = 1'b0;
    if (rst_at >= 0) begin
      for (int j = 0; j < 3; j++) begin
        rst_n = 1'b1; fifo_full = 1'b1; seq_stb = 1'b1; fifo_empty = 1'b0; fml_ack = 1'b0;
        @(negedge clk);
        chk_quiet("postrst");
        chk("postrst_busy", busy, 1'b0);
        tick();
      end
    end
  endtask

  initial begin
    k = 0; exp_pix = 0; exp_und = 0; exp_hit = 0; exp_miss = 0; exp_fadr = '0; plan_adr = '0;
    ev_hit = 0; ev_miss = 0; ev_load = 0;
    rst_n = 0; cache_en = 0; seq_stb = 0; fifo_full = 0; fifo_empty = 0; fml_ack = 0;
    dcb_hit = 0; clr_stats = 0; burst_thresh = '0; fifo_level = '0; pix_div = 2'd3;
    start_addr = '0; seq_adr = '0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) reset_cycle();

    // Pixel cadence and idle pacing, then a stretch with an empty FIFO to trip underrun
    repeat (20) idle_cycle(1'b0);
    repeat (6) idle_cycle(1'b1);

    // Threshold boundary: one word over blocks everything, equal starts at once
    rst_n = 1; clr_stats = 0; burst_thresh = 10'd300; fifo_level = 10'd301; fifo_full = 0;
    seq_stb = 1; cache_en = 1; dcb_hit = 1; fml_ack = 0; fifo_empty = 0;
    @(negedge clk);
    chk_quiet("over_thresh");
    chk("over_thresh_busy", busy, 1'b0);
    tick();
    run_burst(1, 0, -1, -1, 300, 19'h00012, 16'h0000);

    // Cache miss with FML ack after 5 waiting cycles
    run_burst(2, 5, -1, -1, -1, -1, -1);
    // Stats clear coinciding with a hit
    run_burst(1, 0, 3, -1, -1, -1, -1);
    run_burst(0, 0, -1, -1, -1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      run_burst($urandom_range(0, 2), $urandom_range(0, 6), ($urandom_range(0, 7) == 0) ? 3 : -1,
                -1, -1, -1, -1);
      repeat ($urandom_range(0, 3)) idle_cycle(1'b0);
    end

    // Reset in the middle of the FML data phase
    run_burst(0, 2, -1, 3 + 2 + 2, -1, -1, -1);
    repeat (4) idle_cycle(1'b0);

    // New divider under reset
    repeat (2) reset_cycle();
    pix_div = 2'($urandom_range(0, 3));
    repeat (2) reset_cycle();
    repeat (30) idle_cycle(1'b0);
    run_burst(1, 0, -1, -1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
